// File: rtl/led_pio_sequencer.sv
// LED PIO sequencer: walks an 8-bit PATTERN out to a 1-bit LED PIO, one bit every PERIOD clocks.
// Oneshot mode (DONE state, CTRL.ONESHOT, STATUS.DONE) exists only when LED_SEQ_ONESHOT_EN is defined.
module led_pio_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_PATTERN = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  state_t      state_q;
  logic        ctrl_en_q;
  logic [2:0]  len_q;
  logic [23:0] period_q;
  logic [7:0]  pattern_q;
  logic [2:0]  step_q;
  logic [23:0] cnt_q;
  logic        m_cs_q;
  logic        m_wn_q;
  logic        m_led_q;
  logic        oneshot_q;
  logic        done_q;

  logic        wr_en;
  logic        ctrl_wr;
  logic        period_wr;
  logic        pattern_wr;
  logic        status_wr;
  logic        run_start;
  logic        run_stop;
  logic        busy;
  logic        last_step;
  logic        oneshot_end;
  logic [2:0]  step_d;
  logic [23:0] load_d;
  logic        unused_wdata;

  assign wr_en      = s_chipselect & ~s_write_n;
  assign ctrl_wr    = wr_en && (s_address == ADDR_CTRL);
  assign period_wr  = wr_en && (s_address == ADDR_PERIOD);
  assign pattern_wr = wr_en && (s_address == ADDR_PATTERN);
  assign status_wr  = wr_en && (s_address == ADDR_STATUS);
  assign run_start  = ctrl_wr && s_writedata[0];
  assign run_stop   = ctrl_wr && !s_writedata[0];

  assign busy        = (state_q == ST_WRITE) || (state_q == ST_COUNT);
  assign last_step   = (step_q == len_q);
  assign oneshot_end = oneshot_q && last_step;
  assign step_d      = last_step ? 3'd0 : step_q + 3'd1;
  // WRITE and the terminal COUNT cycle account for two cycles of the period, so small periods clamp to 2.
  assign load_d      = (period_q < 24'd3) ? 24'd0 : period_q - 24'd2;

  assign unused_wdata = &{1'b0, s_writedata[31:24]};

`ifdef LED_SEQ_ONESHOT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        oneshot_q <= s_writedata[1];
      end
      if (run_start) begin
        done_q <= 1'b0;
      end else if ((state_q == ST_WRITE) && oneshot_end && !run_stop) begin
        done_q <= 1'b1;
      end
    end
  end
`else
  assign oneshot_q = 1'b0;
  assign done_q    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en_q <= 1'b0;
      len_q     <= 3'd0;
      period_q  <= 24'd0;
      pattern_q <= 8'd0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en_q <= s_writedata[0];
        len_q     <= s_writedata[6:4];
      end else if ((state_q == ST_WRITE) && oneshot_end) begin
        ctrl_en_q <= 1'b0;
      end
      if (period_wr) begin
        period_q <= s_writedata[23:0];
      end
      if (pattern_wr) begin
        pattern_q <= s_writedata[7:0];
      end
    end
  end

  // Master strobe and data are registered alongside the state so they line up with WRITE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      step_q  <= 3'd0;
      cnt_q   <= 24'd0;
      m_cs_q  <= 1'b0;
      m_wn_q  <= 1'b1;
      m_led_q <= 1'b0;
    end else begin
      m_cs_q <= 1'b0;
      m_wn_q <= 1'b1;
      if (run_start) begin
        state_q <= ST_WRITE;
        step_q  <= 3'd0;
        m_cs_q  <= 1'b1;
        m_wn_q  <= 1'b0;
        m_led_q <= pattern_q[0];
      end else if (run_stop) begin
        state_q <= ST_IDLE;
        step_q  <= 3'd0;
      end else begin
        case (state_q)
          ST_WRITE: begin
            cnt_q <= load_d;
            if (oneshot_end) begin
              state_q <= ST_DONE;
              step_q  <= 3'd0;
            end else begin
              state_q <= ST_COUNT;
            end
          end
          ST_COUNT: begin
            if (cnt_q == 24'd0) begin
              state_q <= ST_WRITE;
              step_q  <= step_d;
              m_cs_q  <= 1'b1;
              m_wn_q  <= 1'b0;
              m_led_q <= pattern_q[step_d];
            end else begin
              cnt_q <= cnt_q - 24'd1;
            end
          end
          default: begin
            if (status_wr) begin
              m_cs_q  <= 1'b1;
              m_wn_q  <= 1'b0;
              m_led_q <= s_writedata[0];
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    s_readdata = 32'd0;
    case (s_address)
      ADDR_CTRL:    s_readdata = {25'd0, len_q, 2'b00, oneshot_q, ctrl_en_q};
      ADDR_PERIOD:  s_readdata = {8'd0, period_q};
      ADDR_PATTERN: s_readdata = {24'd0, pattern_q};
      ADDR_STATUS:  s_readdata = {27'd0, step_q, done_q, busy};
      default:      s_readdata = 32'd0;
    endcase
  end

  assign m_address    = 2'd0;
  assign m_chipselect = m_cs_q;
  assign m_write_n    = m_wn_q;
  assign m_writedata  = {31'd0, m_led_q};

endmodule

// File: doc/led_pio_sequencer.md
LED_PIO_SEQUENCER -- requirements
Module: led_pio_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port s_address, input, 2, control-slave register select.
REQ-004 SHALL have port s_chipselect, input, 1, control-slave select.
REQ-005 SHALL have port s_write_n, input, 1, control-slave write strobe, active-low.
REQ-006 SHALL have port s_writedata, input, 32, control-slave write data.
REQ-007 SHALL have port s_readdata, output, 32, control-slave read data, combinational from s_address, zero-latency.
REQ-008 SHALL have port m_address, output, 2, LED PIO address, constant 0.
REQ-009 SHALL have port m_chipselect, output, 1, LED PIO select, registered one-cycle pulse.
REQ-010 SHALL have port m_write_n, output, 1, LED PIO write strobe, registered; equals ~m_chipselect.
REQ-011 SHALL have port m_writedata, output, 32, LED PIO data; bits[31:1] = 0.

Function
REQ-012 SHALL decode slave writes as s_chipselect && ~s_write_n.
REQ-013 SHALL provide registers at these addresses:
- 0 CTRL: bit0 EN; bit1 ONESHOT; bits[6:4] LEN = last step index.
- 1 PERIOD: bits[23:0], in clk cycles.
- 2 PATTERN: bits[7:0].
- 3 STATUS: read bit0 BUSY, bit1 DONE, bits[4:2] STEP; write bit0 = MANUAL value.
REQ-014 SHALL implement states IDLE, WRITE, COUNT, DONE.
REQ-015 IDLE -> WRITE on the cycle after a CTRL write with EN=1; STEP is set to 0.
REQ-016 WRITE lasts one cycle: m_chipselect=1, m_write_n=0, m_writedata[0]=PATTERN[STEP]; counter loads PERIOD-2.
REQ-017 From WRITE, next state SHALL be COUNT, except in the oneshot-complete case of REQ-022.
REQ-018 COUNT decrements the counter each cycle; at counter==0, next state is WRITE and STEP advances (STEP==LEN -> 0).
REQ-019 Consecutive LED writes SHALL be exactly PERIOD cycles apart; PERIOD values 0, 1 or 2 behave as 2.
REQ-020 A CTRL write with EN=0 in any non-IDLE state SHALL go to IDLE next cycle: STEP=0, no further master writes, LED keeps last value.
REQ-021 PERIOD/PATTERN writes mid-run SHALL take effect at the next counter load / next WRITE; CTRL LEN change applies at the next STEP advance.
REQ-022 With ONESHOT=1, the WRITE at STEP==LEN SHALL go to DONE, clear EN and set DONE; DONE -> WRITE on a CTRL write with EN=1; DONE clears on that write.
REQ-023 A STATUS write in IDLE or DONE SHALL issue one master write next cycle with m_writedata[0]=MANUAL; it SHALL be ignored while BUSY.
REQ-024 A STATUS write simultaneous with a CTRL EN=1 write is impossible (single address); a CTRL EN=1 write while BUSY SHALL restart at STEP=0 via WRITE.
REQ-025 BUSY SHALL be 1 in WRITE and COUNT, else 0; unused readdata bits read 0.

Reset
REQ-026 On reset_n low, outputs SHALL immediately reach these values: state IDLE; m_chipselect=0; m_write_n=1; m_writedata=0.
REQ-027 On reset_n low, registers SHALL immediately reach these values: CTRL=0, PERIOD=0, PATTERN=0, STEP=0, DONE=0, counter=0.
REQ-028 Reset mid-run SHALL abort any pending master write in the same instant.

Configuration
REQ-029 With macro LED_SEQ_ONESHOT_EN defined, oneshot mode and the DONE state/bit SHALL exist as specified.
REQ-030 Without LED_SEQ_ONESHOT_EN, CTRL bit1 and STATUS bit1 SHALL read 0, writes to them SHALL be ignored, and the block SHALL always run continuously.

Verification
REQ-031 Bench SHALL cover: PATTERN=0xA5, LEN=7, PERIOD=10, EN=1 -> writes at 10-cycle spacing carrying bits 1,0,1,0,0,1,0,1, then repeating.
REQ-032 Bench SHALL cover: PERIOD=1 -> writes every 2 cycles.
REQ-033 Bench SHALL cover: ONESHOT=1, LEN=2, PATTERN=0x05 -> exactly 3 writes carrying bits 1,0,1; STATUS reads 0x2 (DONE=1, BUSY=0); CTRL.EN reads 0.
REQ-034 Bench SHALL cover: EN=0 written in COUNT -> no further m_chipselect pulses; STATUS reads 0.
REQ-035 Bench SHALL cover: STATUS write 1 while IDLE -> one write with m_writedata=1 next cycle; the same write while BUSY -> no extra pulse.
REQ-036 Bench SHALL cover: reset_n asserted during WRITE -> m_chipselect=0 immediately; all registers read 0.
